// File: rtl/tmds_link_pkg.sv
// Shared types and TMDS control-token constants for the link bring-up sequencer.
package tmds_link_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SERDES_RST,
    FLUSH,
    WAIT_FRAME,
    RUN
  } link_state_e;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = TOKEN_00;
      2'b01:   tok = TOKEN_01;
      2'b10:   tok = TOKEN_10;
      default: tok = TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_link_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by synchronous reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tmds_link_ctrl.sv
// TMDS link bring-up: qualify MMCM lock, pulse serdes reset, flush control tokens,
// then start video on a vsync rising edge. All outputs are registered from next state.
//
// state      | meaning
// WAIT_LOCK  | serdes held in reset, counting consecutive synchronized-lock cycles
// SERDES_RST | lock qualified, serdes reset held for a fixed window
// FLUSH      | serdes released, control tokens only
// WAIT_FRAME | tokens until the next vsync rising edge
// RUN        | link up, encoded video passed through while vde is high
module tmds_link_ctrl
  import tmds_link_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SERDES_RST_CYCLES  = 16,
  parameter int FLUSH_CYCLES       = 64,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  i_pixel_clk,
  input  logic                  i_rst,
  input  logic                  i_mmcm_locked,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic                  i_vde,
  input  logic [9:0]            i_tmds_ch0_in,
  input  logic [9:0]            i_tmds_ch1_in,
  input  logic [9:0]            i_tmds_ch2_in,
  output logic [9:0]            o_tmds_ch0_out,
  output logic [9:0]            o_tmds_ch1_out,
  output logic [9:0]            o_tmds_ch2_out,
  output logic                  o_serdes_rst,
  output logic                  o_link_up,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt
);

  localparam int CNT_MAX_12 = (LOCK_STABLE_CYCLES > SERDES_RST_CYCLES) ?
                              LOCK_STABLE_CYCLES : SERDES_RST_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_12 > FLUSH_CYCLES) ? CNT_MAX_12 : FLUSH_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX);

  link_state_e           r_state;
  link_state_e           w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_vsync_d;
  logic                  w_lock_s;
  logic                  w_loss;
  logic [9:0]            r_ch0;
  logic [9:0]            r_ch1;
  logic [9:0]            r_ch2;
  logic                  r_serdes_rst;
  logic                  r_link_up;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  sync_2ff u_lock_sync (
    .i_clk (i_pixel_clk),
    .i_rst (i_rst),
    .i_d   (i_mmcm_locked),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) r_state <= WAIT_LOCK;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_loss = (r_state != WAIT_LOCK) && !w_lock_s;
    case (r_state)
      WAIT_LOCK:  if (w_lock_s && (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1))) w_next = SERDES_RST;
      SERDES_RST: if (r_cnt == CNT_W'(SERDES_RST_CYCLES - 1)) w_next = FLUSH;
      FLUSH:      if (r_cnt == CNT_W'(FLUSH_CYCLES - 1)) w_next = WAIT_FRAME;
      WAIT_FRAME: if (i_vsync && !r_vsync_d) w_next = RUN;
      RUN:        w_next = RUN;
      default:    w_next = WAIT_LOCK;
    endcase
    // Lock loss overrides every other transition.
    if (w_loss) w_next = WAIT_LOCK;
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_vsync_d    <= 1'b0;
      r_serdes_rst <= 1'b1;
      r_link_up    <= 1'b0;
      r_loss_cnt   <= '0;
      r_ch0        <= TOKEN_00;
      r_ch1        <= TOKEN_00;
      r_ch2        <= TOKEN_00;
    end else begin
      r_vsync_d <= i_vsync;

      if (w_next != r_state)                      r_cnt <= '0;
      else if (r_state == WAIT_LOCK && !w_lock_s) r_cnt <= '0;
      else if (r_state inside {WAIT_LOCK, SERDES_RST, FLUSH})
        r_cnt <= r_cnt + CNT_W'(1);

      r_serdes_rst <= (w_next == WAIT_LOCK) || (w_next == SERDES_RST);
      r_link_up    <= (w_next == RUN);

      if (w_loss && (r_loss_cnt != '1)) r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);

      if (w_next == RUN && i_vde) begin
        r_ch0 <= i_tmds_ch0_in;
        r_ch1 <= i_tmds_ch1_in;
        r_ch2 <= i_tmds_ch2_in;
      end else begin
        r_ch0 <= ctrl_token({i_vsync, i_hsync});
        r_ch1 <= TOKEN_00;
        r_ch2 <= TOKEN_00;
      end
    end
  end

  assign o_tmds_ch0_out  = r_ch0;
  assign o_tmds_ch1_out  = r_ch1;
  assign o_tmds_ch2_out  = r_ch2;
  assign o_serdes_rst    = r_serdes_rst;
  assign o_link_up       = r_link_up;
  assign o_lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Bench for tmds_link_ctrl: timeline reference model feeds a scoreboard queue checked by a monitor.
module tb_tmds_link_ctrl;

  localparam int LOCK_N  = 8;
  localparam int RST_N   = 4;
  localparam int FLUSH_N = 6;
  localparam int LW      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic          vde = 1'b0;
  logic [9:0]    in0 = '0;
  logic [9:0]    in1 = '0;
  logic [9:0]    in2 = '0;
  logic [9:0]    out0, out1, out2;
  logic          serdes_rst, link_up;
  logic [LW-1:0] loss_cnt;

  tmds_link_ctrl #(
    .LOCK_STABLE_CYCLES (LOCK_N),
    .SERDES_RST_CYCLES  (RST_N),
    .FLUSH_CYCLES       (FLUSH_N),
    .LOSS_CNT_W         (LW)
  ) dut (
    .i_pixel_clk     (clk),
    .i_rst           (rst),
    .i_mmcm_locked   (locked),
    .i_hsync         (hsync),
    .i_vsync         (vsync),
    .i_vde           (vde),
    .i_tmds_ch0_in   (in0),
    .i_tmds_ch1_in   (in1),
    .i_tmds_ch2_in   (in2),
    .o_tmds_ch0_out  (out0),
    .o_tmds_ch1_out  (out1),
    .o_tmds_ch2_out  (out2),
    .o_serdes_rst    (serdes_rst),
    .o_link_up       (link_up),
    .o_lock_loss_cnt (loss_cnt)
  );

  typedef struct {
    logic          srst;
    logic          up;
    logic [LW-1:0] cnt;
    logic [9:0]    c0, c1, c2;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Reference model: tracks lock qualification and the elapsed time since it,
  // deriving the bring-up phase from that elapsed time.
  logic          m_s1 = 1'b0, m_s2 = 1'b0;
  int            m_stable = 0;
  int            m_cyc = 0;
  int            m_qual_t = 0;
  bit            m_link = 0;
  bit            m_run = 0;
  logic [LW-1:0] m_loss = '0;
  logic          m_vs_prev = 1'b0;

  task automatic model_step();
    exp_t e;
    logic lock_s;
    int   el;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_link = 0; m_run = 0;
      m_loss = '0; m_vs_prev = 0;
      e.srst = 1; e.up = 0; e.cnt = '0;
      e.c0 = 10'h354; e.c1 = 10'h354; e.c2 = 10'h354;
    end else begin
      lock_s = m_s2;
      m_s2   = m_s1;
      m_s1   = locked;
      if (m_link) begin
        if (!lock_s) begin
          m_link = 0; m_run = 0; m_stable = 0;
          if (m_loss != '1) m_loss = m_loss + 1'b1;
        end else if (!m_run) begin
          el = m_cyc - m_qual_t;
          if (el >= RST_N + FLUSH_N + 1 && vsync && !m_vs_prev) m_run = 1;
        end
      end else begin
        if (lock_s) begin
          m_stable++;
          if (m_stable == LOCK_N) begin
            m_link = 1; m_qual_t = m_cyc; m_stable = 0;
          end
        end else m_stable = 0;
      end
      m_vs_prev = vsync;
      e.srst = !m_link || ((m_cyc - m_qual_t) < RST_N);
      e.up   = m_run;
      e.cnt  = m_loss;
      if (m_run && vde) begin
        e.c0 = in0; e.c1 = in1; e.c2 = in2;
      end else begin
        e.c0 = tok({vsync, hsync}); e.c1 = 10'h354; e.c2 = 10'h354;
      end
    end
    m_cyc++;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s at t=%0t: got %h want %h", nm, $time, act, want);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("serdes_rst", 10'(serdes_rst), 10'(e.srst));
        chk("link_up",    10'(link_up),    10'(e.up));
        chk("loss_cnt",   10'(loss_cnt),   10'(e.cnt));
        chk("ch0",        out0,            e.c0);
        chk("ch1",        out1,            e.c1);
        chk("ch2",        out2,            e.c2);
      end
    end
  end

  logic k_rst  = 1'b1;
  logic k_lock = 1'b0;
  int   k_vs   = 2;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst    = k_rst;
      locked = k_lock;
      hsync  = 1'($urandom_range(0, 1));
      vsync  = (k_vs == 2) ? 1'($urandom_range(0, 1)) : (k_vs == 1);
      vde    = 1'($urandom_range(0, 1));
      in0    = 10'($urandom_range(0, 1023));
      in1    = 10'($urandom_range(0, 1023));
      in2    = 10'($urandom_range(0, 1023));
      model_step();
    end
  endtask

  task automatic drv(input logic vs, input logic hs, input logic de,
                     input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    @(negedge clk);
    rst = 1'b0; locked = 1'b1;
    vsync = vs; hsync = hs; vde = de;
    in0 = a; in1 = b; in2 = c;
    model_step();
  endtask

  initial begin
    // reset, then a one-cycle lock glitch
    k_rst = 1; k_lock = 0; k_vs = 2; cyc(3);
    k_rst = 0;
    k_lock = 1; cyc(5);
    k_lock = 0; cyc(1);
    // bring-up with vsync already high when WAIT_FRAME is entered
    k_lock = 1; k_vs = 0; cyc(14);
    k_vs = 1; cyc(10);
    k_vs = 0; cyc(2);
    k_vs = 1; cyc(2);
    drv(1'b0, 1'b0, 1'b1, 10'h2AA, 10'h155, 10'h3F0);
    drv(1'b1, 1'b0, 1'b0, 10'h2AA, 10'h155, 10'h3F0);
    k_vs = 2; cyc(30);
    // loss in RUN, recover, second loss, then reset during FLUSH
    k_lock = 0; cyc(4);
    k_lock = 1; cyc(40);
    k_lock = 0; cyc(3);
    k_lock = 1; cyc(16);
    k_rst = 1; cyc(1);
    k_rst = 0;
    // five loss events at varying phases saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      k_lock = 1; cyc(12 + int'($urandom_range(0, 20)));
      k_lock = 0; cyc(3);
    end
    k_lock = 1; cyc(30);
    // random soak
    for (int i = 0; i < 1500; i++) begin
      k_lock = ($urandom_range(0, 63) != 0);
      k_rst  = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    k_rst = 0; k_lock = 1; cyc(2);
    @(posedge clk);
    #2;
    chk("queue_drained", 10'(q.size()), 10'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
